alu_control_fsm: RTL and testbench

ALU_CONTROL_FSM -- requirements
Module: alu_control_fsm

---
 rtl/alu_control_fsm.sv | 167 ++++++++++++++++
 tb/tb_alu_control_fsm.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_control_fsm.sv
// Multi-cycle control FSM for a small RV32I-style datapath.
// Every instruction walks IF -> ID -> EX -> MEM -> WB.
// The instruction is latched at the end of IF and decoded only from that copy.
// The EX-stage zero flag is latched at the end of EX to pick the next PC.
module alu_control_fsm #(
    parameter logic [2:0] S_IF  = 3'b000,
    parameter logic [2:0] S_ID  = 3'b001,
    parameter logic [2:0] S_EX  = 3'b010,
    parameter logic [2:0] S_MEM = 3'b011,
    parameter logic [2:0] S_WB  = 3'b100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        load_instr,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        load_pc,
    output logic        pc_src,
    output logic        illegal
);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [31:0] instrReg_q;
    logic        branchTaken_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        isR;
    logic        isI;
    logic        isLw;
    logic        isSw;
    logic        isBeq;
    logic        isIllegal;
    logic [3:0]  aluOpDec;
    logic        unusedInstrBits;

    assign opcode    = instrReg_q[6:0];
    assign funct3    = instrReg_q[14:12];
    assign funct7b5  = instrReg_q[30];
    assign isR       = (opcode == OPC_R);
    assign isI       = (opcode == OPC_I);
    assign isLw      = (opcode == OPC_LW);
    assign isSw      = (opcode == OPC_SW);
    assign isBeq     = (opcode == OPC_BEQ);
    assign isIllegal = !(isR || isI || isLw || isSw || isBeq);

    // Register fields and immediates belong to the datapath, not to this block.
    assign unusedInstrBits = ^{instrReg_q[31], instrReg_q[29:15], instrReg_q[11:7]};

    // The sequence never branches: five cycles per instruction, whatever the opcode.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID:    state_d = S_EX;
            S_EX:    state_d = S_MEM;
            S_MEM:   state_d = S_WB;
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // State, latched instruction and branch decision; reset aborts the instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IF;
            instrReg_q    <= 32'd0;
            branchTaken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF) begin
                instrReg_q <= instr;
            end
            if (state_q == S_EX) begin
                branchTaken_q <= isBeq & zero;
            end
        end
    end

    // ALU operation from opcode class and funct3/funct7[5]; I-type never subtracts.
    always_comb begin
        aluOpDec = ALU_ADD;
        if (isR || isI) begin
            case (funct3)
                3'b000:  aluOpDec = (isR && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  aluOpDec = ALU_SLL;
                3'b010:  aluOpDec = ALU_SLT;
                3'b011:  aluOpDec = ALU_ADD;
                3'b100:  aluOpDec = ALU_XOR;
                3'b101:  aluOpDec = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  aluOpDec = ALU_OR;
                3'b111:  aluOpDec = ALU_AND;
                default: aluOpDec = ALU_ADD;
            endcase
        end else if (isBeq) begin
            aluOpDec = ALU_SUB;
        end
    end

    // Control outputs from state and latched data only; rst forces the idle pattern at once.
    always_comb begin
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        load_instr = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        load_pc    = 1'b0;
        pc_src     = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    load_instr = 1'b1;
                end
                S_EX: begin
                    alu_op  = aluOpDec;
                    alu_src = isI || isLw || isSw;
                end
                S_MEM: begin
                    alu_op    = aluOpDec;
                    alu_src   = isI || isLw || isSw;
                    mem_read  = isLw;
                    mem_write = isSw;
                end
                S_WB: begin
                    alu_op     = aluOpDec;
                    alu_src    = isI || isLw || isSw;
                    reg_write  = isR || isI || isLw;
                    mem_to_reg = isLw;
                    load_pc    = 1'b1;
                    pc_src     = branchTaken_q;
                    illegal    = isIllegal;
                end
                default: begin
                    alu_op = ALU_ADD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_fsm.sv
// Directed, table-driven bench for alu_control_fsm.
// Each vector is walked through all five states and the full output word is checked every cycle.
module tb_alu_control_fsm;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        load_instr;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        load_pc;
    logic        pc_src;
    logic        illegal;

    int numCompared   = 0;
    int numMismatched = 0;

    // Output word order: {alu_op, alu_src, load_instr, mem_read, mem_write, mem_to_reg, reg_write, load_pc, pc_src, illegal}
    localparam logic [12:0] IDLE_WORD = 13'b0010_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] IF_WORD   = 13'b0010_0_1_0_0_0_0_0_0_0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        zEx;
        logic        zMem;
        logic [3:0]  aluOp;
        logic        aluSrc;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
        logic        memToReg;
        logic        pcSrc;
        logic        illegal;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    alu_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .load_instr (load_instr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .load_pc    (load_pc),
        .pc_src     (pc_src),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word for a vector in a given state (0=IF .. 4=WB).
    function automatic logic [12:0] expectedWord(input vec_t v, input int p);
        case (p)
            0:       return IF_WORD;
            1:       return IDLE_WORD;
            2:       return {v.aluOp, v.aluSrc, 8'b0};
            3:       return {v.aluOp, v.aluSrc, 1'b0, v.memRead, v.memWrite, 5'b0};
            default: return {v.aluOp, v.aluSrc, 3'b0, v.memToReg, v.regWrite, 1'b1, v.pcSrc, v.illegal};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {alu_op, alu_src, load_instr, mem_read, mem_write, mem_to_reg, reg_write, load_pc, pc_src, illegal};
        numCompared++;
        if (act !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Runs one instruction from S_IF; abortPhase < 5 raises rst mid-cycle in that state.
    task automatic applyStimulus(input vec_t v, input int abortPhase);
        for (int p = 0; p < 5; p++) begin
            instr = (p == 0) ? v.instr : $urandom;
            if (p == 2)      zero = v.zEx;
            else if (p == 3) zero = v.zMem;
            else             zero = 1'($urandom_range(0, 1));
            #3;
            checkOutput($sformatf("%s p%0d", v.name, p), expectedWord(v, p));
            if (p == abortPhase) begin
                #2 rst = 1'b1;
                #1 checkOutput($sformatf("%s async abort", v.name), IDLE_WORD);
                @(posedge clk);
                #1 checkOutput($sformatf("%s held in reset", v.name), IDLE_WORD);
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        //           name        instr          zEx   zMem  aluOp    src   mRd   mWr   rWr   m2r   pcS   ill
        vecs[0]  = '{"sub",      32'h40B50533, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"srai",     32'h4020D093, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"addi",     32'h00000093, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"lw",       32'h0000A103, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"sw",       32'h0020A023, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"beq_t",    32'h00208463, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{"beq_t_z0", 32'h00208463, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{"beq_nt",   32'h00208463, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"illegal",  32'h0000007F, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{"xor",      32'h00B54533, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"addi_f7",  32'h40000093, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"sltu",     32'h00003033, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"sltiu",    32'h00003013, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{"srl",      32'h00005033, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{"and",      32'h00007033, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{"or",       32'h00006033, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{"slt",      32'h00002033, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{"sll",      32'h00001033, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst   = 1'b1;
        instr = 32'h00B54533;
        zero  = 1'b0;
        #2 checkOutput("reset idle", IDLE_WORD);
        @(posedge clk);
        #3 checkOutput("reset across edge", IDLE_WORD);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], 5);
        end

        // Abort an SW in S_MEM, then confirm a clean five-cycle instruction follows.
        applyStimulus(vecs[4], 3);
        applyStimulus(vecs[3], 5);
        applyStimulus(vecs[5], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
